// File: rtl/switch_led_display.sv
// Board I/O helper block with three functions:
// a 12-LED one-hot running light, an 8-to-3 priority encoder on the switches,
// and a single active-low 7-segment digit that shows the encoder result.
module switch_led_display #(
    parameter int unsigned LED_PERIOD = 5000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sw,
    output logic [11:0] led,
    output logic [2:0]  enc_y,
    output logic        enc_valid,
    output logic [7:0]  seg
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(LED_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      led_q, led_d;
    logic [2:0]       enc_y_q, enc_y_d;
    logic             enc_valid_q, enc_valid_d;
    logic [7:0]       seg_q, seg_d;

    logic [7:0]       enc_x;
    logic             enc_en;
    logic             disp_en;
    logic [3:0]       num;

    assign enc_x   = sw[7:0];
    assign enc_en  = sw[8];
    assign disp_en = sw[9];

    // Rotation counter and running-light pattern: rotate left once per period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        led_d = led_q;
        if (cnt_q == CntLast) begin
            cnt_d = '0;
            led_d = {led_q[10:0], led_q[11]};
        end
    end

    // Priority encoder: highest set bit wins; ascending loop lets later bits overwrite.
    always_comb begin
        enc_y_d     = 3'd0;
        enc_valid_d = 1'b0;
        if (enc_en) begin
            for (int i = 0; i < 8; i++) begin
                if (enc_x[i]) begin
                    enc_y_d = 3'(i);
                end
            end
            enc_valid_d = |enc_x;
        end
    end

    // Hex-to-7-segment decode of the same-cycle encoder result; dp stays off.
    always_comb begin
        num   = {1'b0, enc_y_d};
        seg_d = 8'hFF;
        if (disp_en) begin
            unique case (num)
                4'h0: seg_d = 8'hC0;
                4'h1: seg_d = 8'hF9;
                4'h2: seg_d = 8'hA4;
                4'h3: seg_d = 8'hB0;
                4'h4: seg_d = 8'h99;
                4'h5: seg_d = 8'h92;
                4'h6: seg_d = 8'h82;
                4'h7: seg_d = 8'hF8;
                4'h8: seg_d = 8'h80;
                4'h9: seg_d = 8'h90;
                4'hA: seg_d = 8'h88;
                4'hB: seg_d = 8'h83;
                4'hC: seg_d = 8'hC6;
                4'hD: seg_d = 8'hA1;
                4'hE: seg_d = 8'h86;
                4'hF: seg_d = 8'h8E;
            endcase
        end
    end

    // State registers with synchronous active-high reset; switches ignored on reset edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            led_q       <= 12'h001;
            enc_y_q     <= 3'd0;
            enc_valid_q <= 1'b0;
            seg_q       <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            enc_y_q     <= enc_y_d;
            enc_valid_q <= enc_valid_d;
            seg_q       <= seg_d;
        end
    end

    assign led       = led_q;
    assign enc_y     = enc_y_q;
    assign enc_valid = enc_valid_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_switch_led_display.sv
// Self-checking bench for switch_led_display with a short LED period.
module tb_switch_led_display;

    localparam int unsigned Period = 4;

    logic        clk;
    logic        rst;
    logic [9:0]  sw;
    logic [11:0] led;
    logic [2:0]  enc_y;
    logic        enc_valid;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    // Reference model state: number of non-reset edges since the last reset edge.
    int edges_since_rst = 0;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    switch_led_display #(
        .LED_PERIOD(Period),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .led      (led),
        .enc_y    (enc_y),
        .enc_valid(enc_valid),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model and compare every output.
    task automatic do_edge(input logic r, input logic [9:0] s);
        int          y;
        int          t;
        logic        v;
        logic [7:0]  sg;
        logic [11:0] l;
        rst = r;
        sw  = s;
        @(posedge clk);
        #1;
        if (r) begin
            edges_since_rst = 0;
            y  = 0;
            v  = 1'b0;
            sg = 8'hFF;
        end else begin
            edges_since_rst++;
            y = 0;
            v = 1'b0;
            if (s[8] && s[7:0] != 8'd0) begin
                // floor(log2(x)) gives the highest set bit
                t = int'(s[7:0]);
                while (t > 1) begin
                    t = t / 2;
                    y++;
                end
                v = 1'b1;
            end
            sg = s[9] ? seg_tbl[y] : 8'hFF;
        end
        l = 12'd1 << ((edges_since_rst / Period) % 12);
        check_eq("led", 32'(led), 32'(l));
        check_eq("enc_y", 32'(enc_y), 32'(y));
        check_eq("enc_valid", 32'(enc_valid), 32'(v));
        check_eq("seg", 32'(seg), 32'(sg));
    endtask

    initial begin
        logic [9:0] dir_sw [6];
        dir_sw = '{10'b11_1000_0101, 10'b11_0000_0000, 10'b11_0001_0100,
                   10'b10_1111_1111, 10'b01_0000_0010, 10'b11_0000_0001};
        rst = 1'b1;
        sw  = 10'd0;

        // Reset held for two edges
        do_edge(1'b1, 10'd0);
        do_edge(1'b1, 10'd0);

        // Full wrap of the running light: 48 edges with switches idle
        for (int i = 0; i < 48; i++) begin
            do_edge(1'b0, 10'd0);
        end

        // Directed encoder/display patterns
        foreach (dir_sw[i]) begin
            do_edge(1'b0, dir_sw[i]);
        end

        // Single-hot sweep with encoder and display enabled
        for (int k = 0; k < 8; k++) begin
            do_edge(1'b0, {2'b11, 8'(1 << k)});
        end

        // Mid-operation reset with led=004 and a valid digit showing
        do_edge(1'b1, 10'd0);
        for (int i = 0; i < 7; i++) begin
            do_edge(1'b0, 10'd0);
        end
        do_edge(1'b0, 10'b11_0000_0100);
        do_edge(1'b1, 10'b11_1111_1111);
        for (int i = 0; i < 2 * Period; i++) begin
            do_edge(1'b0, 10'b11_0010_0000);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            do_edge(($urandom_range(0, 24) == 0), 10'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
